weight_read_server: RTL and testbench

//  Read-side responder for the weight-tiling address generator's 16-lane address/valid bus.

---
 rtl/weight_read_server_pkg.sv | 15 +
 rtl/weight_read_server_lane_port.sv | 71 +++++++
 rtl/weight_read_server.sv | 108 ++++++++++
 tb/tb_weight_read_server.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/weight_read_server_pkg.sv
// Shared sizing defaults and FSM state encoding for the weight read server.
package weight_read_server_pkg;

  localparam int LANES = 16;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 9408;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_SERVING = 2'd2
  } state_e;

endpackage

// File: rtl/weight_read_server_lane_port.sv
// Single read lane: range check, word index for the shared register file,
// byte select from the returned word and the registered response.
module weight_lane_port
  import weight_read_server_pkg::*;
#(
  parameter int LANES = weight_read_server_pkg::LANES,
  parameter int AW    = weight_read_server_pkg::AW,
  parameter int DW    = weight_read_server_pkg::DW,
  parameter int DEPTH = weight_read_server_pkg::DEPTH,
  parameter int IW    = $clog2(DEPTH / LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                serving,
  input  logic                addr_valid,
  input  logic [AW-1:0]       addr,
  input  logic [LANES*DW-1:0] row,
  output logic [IW-1:0]       word_idx,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic                rd_error
);

  localparam int OW = $clog2(LANES);

  logic          in_range;
  logic [OW-1:0] byte_off;
  logic [DW-1:0] rd_data_d, rd_data_q;
  logic          rd_valid_d, rd_valid_q;
  logic          rd_error_d, rd_error_q;

  // Range check at full address width; out-of-range addresses index word 0 harmlessly.
  always_comb begin
    in_range = (addr < AW'(DEPTH));
    word_idx = in_range ? IW'(addr / AW'(LANES)) : '0;
    byte_off = OW'(addr % AW'(LANES));
  end

  // Response decode: data only for in-range reads while serving, error otherwise.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    rd_error_d = 1'b0;
    if (addr_valid) begin
      if (serving && in_range) begin
        rd_data_d  = row[byte_off*DW +: DW];
        rd_valid_d = 1'b1;
      end else begin
        rd_error_d = 1'b1;
      end
    end
  end

  // Output register giving the fixed one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_error_q <= rd_error_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_error = rd_error_q;

endmodule

// File: rtl/weight_read_server.sv
// Weight read server: sequential beat loader into a wide register file and
// LANES independent registered read ports for the systolic array.
module weight_read_server
  import weight_read_server_pkg::*;
#(
  parameter int LANES = weight_read_server_pkg::LANES,
  parameter int AW    = weight_read_server_pkg::AW,
  parameter int DW    = weight_read_server_pkg::DW,
  parameter int DEPTH = weight_read_server_pkg::DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_loadStart,
  input  logic                io_wrValid,
  input  logic [LANES*DW-1:0] io_wrData,
  output logic                io_wrReady,
  output logic                io_loaded,
  input  logic [LANES*AW-1:0] io_rdAddr,
  input  logic [LANES-1:0]    io_addrValid,
  output logic [LANES*DW-1:0] io_rdData,
  output logic [LANES-1:0]    io_rdValid,
  output logic [LANES-1:0]    io_rdError
);

  localparam int BEATS = DEPTH / LANES;
  localparam int CW    = $clog2(BEATS);

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          wr_ready_d, wr_ready_q;
  logic          loaded_d, loaded_q;
  logic          wr_en;

  logic [LANES*DW-1:0] mem_q [BEATS];

  logic [CW-1:0]       lane_idx [LANES];
  logic [LANES*DW-1:0] lane_row [LANES];

  // Next-state logic: loadStart overrides everything, including a same-cycle beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (io_loadStart) begin
      state_d = ST_LOADING;
      cnt_d   = '0;
    end else if (state_q == ST_LOADING && io_wrValid) begin
      wr_en = 1'b1;
      if (cnt_q == CW'(BEATS - 1)) begin
        state_d = ST_SERVING;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    wr_ready_d = (state_d == ST_LOADING);
    loaded_d   = (state_d == ST_SERVING);
  end

  // FSM, beat counter and registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      wr_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= wr_ready_d;
      loaded_q   <= loaded_d;
    end
  end

  // Register file write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[cnt_q] <= io_wrData;
    end
  end

  assign io_wrReady = wr_ready_q;
  assign io_loaded  = loaded_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_row[i] = mem_q[lane_idx[i]];

    weight_lane_port #(
      .LANES (LANES),
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (CW)
    ) u_lane (
      .clk        (clock),
      .rst_n      (reset),
      .serving    (state_q == ST_SERVING),
      .addr_valid (io_addrValid[i]),
      .addr       (io_rdAddr[i*AW +: AW]),
      .row        (lane_row[i]),
      .word_idx   (lane_idx[i]),
      .rd_data    (io_rdData[i*DW +: DW]),
      .rd_valid   (io_rdValid[i]),
      .rd_error   (io_rdError[i])
    );
  end

endmodule

// File: tb/tb_weight_read_server.sv
// Directed self-checking bench for weight_read_server.
module tb_weight_read_server;

  localparam int LANES = 16;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 9408;
  localparam int BEATS = DEPTH / LANES;

  logic                clock;
  logic                reset;
  logic                io_loadStart;
  logic                io_wrValid;
  logic [LANES*DW-1:0] io_wrData;
  logic                io_wrReady;
  logic                io_loaded;
  logic [LANES*AW-1:0] io_rdAddr;
  logic [LANES-1:0]    io_addrValid;
  logic [LANES*DW-1:0] io_rdData;
  logic [LANES-1:0]    io_rdValid;
  logic [LANES-1:0]    io_rdError;

  int n_checks = 0;
  int n_pass   = 0;

  weight_read_server #(
    .LANES (LANES),
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_loadStart (io_loadStart),
    .io_wrValid   (io_wrValid),
    .io_wrData    (io_wrData),
    .io_wrReady   (io_wrReady),
    .io_loaded    (io_loaded),
    .io_rdAddr    (io_rdAddr),
    .io_addrValid (io_addrValid),
    .io_rdData    (io_rdData),
    .io_rdValid   (io_rdValid),
    .io_rdError   (io_rdError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] beat_data(input int b, input bit inv);
    logic [LANES*DW-1:0] d;
    logic [7:0]          v;
    for (int k = 0; k < LANES; k++) begin
      v = 8'(b * LANES + k);
      d[k*DW +: DW] = inv ? ~v : v;
    end
    return d;
  endfunction

  task automatic set_lane(input int lane, input int addr);
    io_rdAddr[lane*AW +: AW] = AW'(addr);
  endtask

  // loadStart pulse (with a junk beat that must be ignored), then nbeats beats.
  task automatic load_image(input bit inv, input int nbeats, output bit saw_loaded);
    saw_loaded   = 1'b0;
    io_loadStart = 1'b1;
    io_wrValid   = 1'b1;
    io_wrData    = {LANES{8'hEE}};
    tick();
    io_loadStart = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      io_wrValid = 1'b1;
      io_wrData  = beat_data(b, inv);
      tick();
      if (b < BEATS - 1) saw_loaded |= io_loaded;
    end
    io_wrValid = 1'b0;
  endtask

  task automatic idle_reads();
    io_addrValid = '0;
    io_rdAddr    = '0;
  endtask

  bit saw;

  initial begin
    reset        = 1'b0;
    io_loadStart = 1'b0;
    io_wrValid   = 1'b0;
    io_wrData    = '0;
    idle_reads();

    // 1. Reset and not-loaded read.
    tick();
    tick();
    reset = 1'b1;
    check("rst_wrReady", 128'(io_wrReady), 128'd0);
    check("rst_loaded",  128'(io_loaded),  128'd0);
    check("rst_rdData",  128'(io_rdData),  128'd0);
    check("rst_rdValid", 128'(io_rdValid), 128'd0);
    check("rst_rdError", 128'(io_rdError), 128'd0);
    io_addrValid = 16'h0001;
    set_lane(0, 0);
    tick();
    idle_reads();
    check("empty_rdError", 128'(io_rdError), 128'h0001);
    check("empty_rdValid", 128'(io_rdValid), 128'h0000);
    tick();
    check("idle_rdError", 128'(io_rdError), 128'h0000);

    // 2. Full load; read during final beat must error.
    load_image(1'b0, BEATS - 1, saw);
    check("load_wrReady", 128'(io_wrReady), 128'd1);
    check("load_loaded_low", 128'(saw), 128'd0);
    io_wrValid   = 1'b1;
    io_wrData    = beat_data(BEATS - 1, 1'b0);
    io_addrValid = 16'h0001;
    set_lane(0, 0);
    tick();
    io_wrValid = 1'b0;
    idle_reads();
    check("last_beat_rdError", 128'(io_rdError), 128'h0001);
    check("done_wrReady", 128'(io_wrReady), 128'd0);
    check("done_loaded",  128'(io_loaded),  128'd1);
    for (int i = 0; i < LANES; i++) set_lane(i, i);
    io_addrValid = 16'hFFFF;
    tick();
    idle_reads();
    check("seq_rdData",  128'(io_rdData),  128'h0F0E0D0C0B0A09080706050403020100);
    check("seq_rdValid", 128'(io_rdValid), 128'hFFFF);
    check("seq_rdError", 128'(io_rdError), 128'h0000);

    // 3. Boundary addresses DEPTH-1 and DEPTH.
    set_lane(3, DEPTH - 1);
    set_lane(4, DEPTH);
    io_addrValid = 16'h0018;
    tick();
    idle_reads();
    check("bound_rdData",  128'(io_rdData),  128'h000000BF000000);
    check("bound_rdValid", 128'(io_rdValid), 128'h0008);
    check("bound_rdError", 128'(io_rdError), 128'h0010);

    // 4. Same address on all lanes, only odd lanes valid.
    for (int i = 0; i < LANES; i++) set_lane(i, 300);
    io_addrValid = 16'hAAAA;
    tick();
    idle_reads();
    check("odd_rdData",  128'(io_rdData),  128'h2C002C002C002C002C002C002C002C00);
    check("odd_rdValid", 128'(io_rdValid), 128'hAAAA);
    check("odd_rdError", 128'(io_rdError), 128'h0000);

    // 5. Reload with inverted data, restarted after 100 beats.
    load_image(1'b1, 100, saw);
    check("reload1_loaded_low", 128'(saw), 128'd0);
    load_image(1'b1, BEATS, saw);
    check("reload2_loaded_low", 128'(saw), 128'd0);
    check("reload_loaded", 128'(io_loaded), 128'd1);
    set_lane(0, 5);
    set_lane(1, DEPTH - 1);
    io_addrValid = 16'h0003;
    tick();
    idle_reads();
    check("reload_rdData",  128'(io_rdData),  128'h40FA);
    check("reload_rdValid", 128'(io_rdValid), 128'h0003);

    // 6. Reset in the middle of a load, then a clean load.
    load_image(1'b0, 50, saw);
    check("mid_wrReady", 128'(io_wrReady), 128'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_wrReady", 128'(io_wrReady), 128'd0);
    check("midrst_loaded",  128'(io_loaded),  128'd0);
    io_wrValid   = 1'b1;
    io_wrData    = beat_data(0, 1'b1);
    io_addrValid = 16'h0001;
    set_lane(0, 0);
    tick();
    io_wrValid = 1'b0;
    idle_reads();
    check("midrst_rdError", 128'(io_rdError), 128'h0001);
    check("midrst_ignore_wr", 128'(io_wrReady), 128'd0);
    load_image(1'b0, BEATS, saw);
    check("final_loaded_low", 128'(saw), 128'd0);
    check("final_loaded", 128'(io_loaded), 128'd1);
    set_lane(0, DEPTH - 1);
    set_lane(1, 300);
    set_lane(2, (1 << AW) - 1);
    io_addrValid = 16'h0007;
    tick();
    idle_reads();
    check("final_rdData",  128'(io_rdData),  128'h2CBF);
    check("final_rdValid", 128'(io_rdValid), 128'h0003);
    check("final_rdError", 128'(io_rdError), 128'h0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
